// File: rtl/mdu_pkg.sv
// mdu_pkg: function codes, sequencer states and op-kind encoding shared by the MDU files.
package mdu_pkg;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;
  typedef struct packed {
    logic div;
    logic sgn;
  } op_t;
  // bit 1 separates DIV* from MULT*, bit 0 set means the unsigned variant
  function automatic op_t op_of(input logic [5:0] f);
    return '{div: f[1], sgn: !f[0]};
  endfunction
endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: EX-stage instruction/operand inputs and stall/result outputs of the MDU.
interface mdu_sequencer_if #(parameter int NB_DATA = 32);
  logic               i_valid;
  logic               i_stall;
  logic [5:0]         i_func;
  logic [NB_DATA-1:0] i_reg_DA;
  logic [NB_DATA-1:0] i_reg_DB;
  logic               o_stall;
  logic               o_busy;
  logic [NB_DATA-1:0] o_result;
  logic               o_result_valid;
  modport master (output i_valid, i_stall, i_func, i_reg_DA, i_reg_DB,
                  input  o_stall, o_busy, o_result, o_result_valid);
  modport slave  (input  i_valid, i_stall, i_func, i_reg_DA, i_reg_DB,
                  output o_stall, o_busy, o_result, o_result_valid);
endinterface

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one shift-add multiply or restoring divide step per cycle over {acc, q}.
// The divide step exists only when MDU_DIV_EN is defined.
module mdu_iter_core
  import mdu_pkg::*;
#(parameter int NB_DATA = 32) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               start_i,
  input  logic               run_i,
`ifdef MDU_DIV_EN
  input  logic               div_i,
  output logic               zero_o,
`endif
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  output logic [NB_DATA-1:0] acc_o,
  output logic [NB_DATA-1:0] q_o,
  output logic               last_o
);
  localparam int NB_CNT = $clog2(NB_DATA);
  logic [NB_DATA-1:0] acc_q, acc_d, q_q, q_d, b_q;
  logic [NB_CNT-1:0]  cnt_q;
  logic [NB_DATA:0]   sum;
`ifdef MDU_DIV_EN
  logic [NB_DATA:0]   shl;
  logic               ge;
`endif
  always_comb begin
    sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
`ifdef MDU_DIV_EN
    shl = {acc_q, q_q[NB_DATA-1]};
    ge = shl >= {1'b0, b_q};
    acc_d = div_i ? (ge ? shl[NB_DATA-1:0] - b_q : shl[NB_DATA-1:0]) : sum[NB_DATA:1];
    q_d = div_i ? {q_q[NB_DATA-2:0], ge} : {sum[0], q_q[NB_DATA-1:1]};
`else
    acc_d = sum[NB_DATA:1];
    q_d = {sum[0], q_q[NB_DATA-1:1]};
`endif
  end
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      acc_q <= '0;
      q_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      acc_q <= '0;
      q_q <= a_i;
      b_q <= b_i;
      cnt_q <= NB_CNT'(NB_DATA - 1);
    end else if (run_i) begin
      acc_q <= acc_d;
      q_q <= q_d;
      cnt_q <= cnt_q - NB_CNT'(1);
    end
  assign acc_o = acc_q;
  assign q_o = q_q;
  assign last_o = cnt_q == '0;
`ifdef MDU_DIV_EN
  assign zero_o = b_q == '0;
`endif
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: HI/LO owner and background multiply/divide sequencer for the MIPS EX stage.
// Define MDU_DIV_EN to include DIV/DIVU; otherwise those codes are ignored.
module mdu_sequencer
  import mdu_pkg::*;
#(parameter int NB_DATA = 32) (
  input  logic           clk,
  input  logic           i_rst_n,
  mdu_sequencer_if.slave bus
);
  state_t             state_q, state_d;
  op_t                op_i;
  logic               md, rec, busy, accept, start, last, neg, sa_i, sb_i, sa_q, sb_q;
  logic [NB_DATA-1:0] hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, acc, quo;
  logic [2*NB_DATA-1:0] prod;
`ifdef MDU_DIV_EN
  logic               div_q, zero;
`endif
  always_comb begin
    op_i = op_of(bus.i_func);
`ifdef MDU_DIV_EN
    md = bus.i_func[5:2] == 4'b0110;
`else
    md = bus.i_func[5:2] == 4'b0110 && !op_i.div;
`endif
    rec = md || bus.i_func[5:2] == 4'b0100;
    busy = state_q != S_IDLE;
    accept = bus.i_valid && rec && !bus.i_stall && !busy;
    start = accept && md;
    sa_i = op_i.sgn && bus.i_reg_DA[NB_DATA-1];
    sb_i = op_i.sgn && bus.i_reg_DB[NB_DATA-1];
    a_mag = sa_i ? -bus.i_reg_DA : bus.i_reg_DA;
    b_mag = sb_i ? -bus.i_reg_DB : bus.i_reg_DB;
  end
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == S_IDLE ? (start ? S_RUN : S_IDLE) :
              state_q == S_RUN  ? (last ? S_FIXUP : S_RUN) : S_IDLE;
  always_comb begin
    bus.o_busy = busy;
    bus.o_stall = bus.i_valid && rec && busy;
    bus.o_result = bus.i_func == F_MFHI ? hi_q : lo_q;
    bus.o_result_valid = accept && (bus.i_func == F_MFHI || bus.i_func == F_MFLO);
  end
  // FIXUP turns the magnitude result back into the signed one
  always_comb begin
    neg = sa_q ^ sb_q;
    prod = neg ? -{acc, quo} : {acc, quo};
    hi_d = accept && bus.i_func == F_MTHI ? bus.i_reg_DA : hi_q;
    lo_d = accept && bus.i_func == F_MTLO ? bus.i_reg_DA : lo_q;
    if (state_q == S_FIXUP) {hi_d, lo_d} = prod;
`ifdef MDU_DIV_EN
    if (state_q == S_FIXUP && div_q) begin
      lo_d = zero ? '1 : neg ? -quo : quo;
      hi_d = sa_q ? -acc : acc;
    end
`endif
  end
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
`ifdef MDU_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (start) begin
        sa_q <= sa_i;
        sb_q <= sb_i;
`ifdef MDU_DIV_EN
        div_q <= op_i.div;
`endif
      end
    end
  mdu_iter_core #(.NB_DATA(NB_DATA)) u_core (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .start_i (start),
    .run_i   (state_q == S_RUN),
`ifdef MDU_DIV_EN
    .div_i   (div_q),
    .zero_o  (zero),
`endif
    .a_i     (a_mag),
    .b_i     (b_mag),
    .acc_o   (acc),
    .q_o     (quo),
    .last_o  (last)
  );
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed and random MDU instruction streams checked against an arithmetic HI/LO model.
module tb_mdu_sequencer;
  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B, ADD = 6'h20;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mdu_sequencer_if #(.NB_DATA(32)) bus();
  mdu_sequencer #(.NB_DATA(32)) dut (.clk(clk), .i_rst_n(rst_n), .bus(bus));
  int total = 0, bad = 0, npush = 0, npop = 0;
  logic [31:0] hi_m = 0, lo_m = 0;
  logic [31:0] sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (bus.o_result_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL result_unexpected act=%h exp=none", bus.o_result);
      end else begin
        npop++;
        chk("result", bus.o_result, sbq.pop_front());
      end
    end

  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] u;
    case (f)
      MULT: begin p = longint'($signed(a)) * longint'($signed(b)); {hi_m, lo_m} = p; end
      MULTU: begin u = 64'(a) * 64'(b); {hi_m, lo_m} = u; end
      DIV, DIVU: if (DIV_EN) begin
        if (b == 0) begin lo_m = '1; hi_m = a; end
        else if (f == DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo_m = a; hi_m = 0; end
        else if (f == DIV) begin lo_m = $signed(a) / $signed(b); hi_m = $signed(a) % $signed(b); end
        else begin lo_m = a / b; hi_m = a % b; end
      end
      MTHI: hi_m = a;
      MTLO: lo_m = a;
      MFHI: begin sbq.push_back(hi_m); npush++; end
      MFLO: begin sbq.push_back(lo_m); npush++; end
      default: ;
    endcase
  endtask

  // call at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int stalls);
    model(f, a, b);
    bus.i_valid = 1'b1;
    bus.i_func = f;
    bus.i_reg_DA = a;
    bus.i_reg_DB = b;
    stalls = 0;
    #1;
    while (bus.o_stall && stalls < 100) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 100) begin
      total++;
      bad++;
      $display("FAIL issue_timeout act=%0d exp=<100", stalls);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_func = 6'h00;
  endtask

  task automatic read_both();
    int s;
    issue(MFHI, 0, 0, s);
    issue(MFLO, 0, 0, s);
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(20));
      4: return -32'($urandom_range(20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int s, n;
    logic [5:0] ops [9] = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, ADD};
    bus.i_valid = 0; bus.i_stall = 0; bus.i_func = 0; bus.i_reg_DA = 0; bus.i_reg_DB = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(bus.o_stall), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_result", bus.o_result, 0);
    chk("rst_rvalid", 32'(bus.o_result_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(MULTU, 32'hFFFFFFFF, 32'h2, s);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (bus.o_busy) n++; else break;
    end
    chk("busy_len", 32'(n), 33);
    @(posedge clk); #1;
    read_both();
    issue(MULT, -32'd3, 32'd5, s);
    issue(ADD, 1, 2, s);
    chk("add_nostall", 32'(s), 0);
    chk("add_busy", 32'(bus.o_busy), 1);
    issue(ADD, 3, 4, s);
    chk("add_nostall2", 32'(s), 0);
    read_both();
    issue(DIV, -32'd7, 32'd2, s);
    chk("div_busy", 32'(bus.o_busy), 32'(DIV_EN));
    read_both();
    issue(DIV, 32'h80000000, 32'hFFFFFFFF, s);
    read_both();
    issue(DIVU, 32'd10, 32'd0, s);
    chk("divu_stall", 32'(s), 0);
    chk("divu_busy", 32'(bus.o_busy), 32'(DIV_EN));
    read_both();
    issue(MULT, 32'h12345, 32'hFFFF0001, s);
    issue(MFLO, 0, 0, s);
    chk("mflo_stall_len", 32'(s), 33);
    issue(MFHI, 0, 0, s);
    bus.i_stall = 1'b1;
    bus.i_valid = 1'b1; bus.i_func = MULT; bus.i_reg_DA = 9; bus.i_reg_DB = 9;
    #1 chk("istall_ostall", 32'(bus.o_stall), 0);
    @(posedge clk); #1;
    chk("istall_busy", 32'(bus.o_busy), 0);
    bus.i_func = MFLO;
    #1 chk("istall_rvalid", 32'(bus.o_result_valid), 0);
    bus.i_valid = 0; bus.i_stall = 0; bus.i_func = 0;
    @(posedge clk); #1;
    issue(MULT, 32'd7, 32'd9, s);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    hi_m = 0; lo_m = 0;
    #1;
    chk("midrst_busy", 32'(bus.o_busy), 0);
    bus.i_func = MFHI;
    #1 chk("midrst_hi", bus.o_result, 0);
    bus.i_func = MFLO;
    #1 chk("midrst_lo", bus.o_result, 0);
    bus.i_func = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(MTHI, 32'h1234, 0, s);
    issue(MFHI, 0, 0, s);
    repeat (60) issue(ops[$urandom_range(8)], rnd(), rnd(), s);
    read_both();
    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sbq.size()), 0);
    chk("sb_pops", 32'(npop), 32'(npush));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide sequencer for the MIPS EX stage. It owns the HI/LO register pair and a shared shift/add–subtract datapath. It decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the function field and runs multi-cycle operations in the background. It stalls the pipeline only when a later HI/LO or MDU instruction would collide with an operation still in progress.

## Interface
- NB_DATA, 32, operand/HI/LO width; must be even and ≥8
- clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  an R-type instruction occupies EX this cycle
- i_stall  in  1  pipeline held externally; blocks acceptance of new ops, running op continues
- i_func  in  6  R-type function field
- i_reg_DA  in  NB_DATA  rs operand, forwarded
- i_reg_DB  in  NB_DATA  rt operand, forwarded
- o_stall  out  1  hold IF/ID/EX; instruction in EX not accepted
- o_busy  out  1  sequencer not IDLE
- o_result  out  NB_DATA  HI (MFHI) or LO (MFLO), otherwise LO
- o_result_valid  out  1  MFHI/MFLO accepted this cycle

## Operation
- Function codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
  - All other codes are ignored.
- Accept condition: `accept = i_valid & recognised & !i_stall & !o_busy`.
- Stall rule: `o_stall = i_valid & recognised & o_busy`. This is combinational and independent of i_stall.
- States: IDLE, RUN, FIXUP.
  - IDLE → RUN when a MULT*/DIV* is accepted. Operands are latched; signed ops latch magnitudes plus sign flags; the iteration counter is set to NB_DATA−1.
  - RUN: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle. The counter decrements. At counter 0 → FIXUP.
  - FIXUP: apply sign correction, write HI/LO, → IDLE.
- Multiply: {HI,LO} = full 2·NB_DATA product, signed or unsigned.
- Divide: LO = quotient, HI = remainder, truncating toward zero. The remainder takes the dividend's sign.
- Divide by zero: LO = all ones, HI = i_reg_DA as latched. Sign fixup is skipped.
- Signed MIN / −1: LO = MIN, HI = 0. This wraps with no exception.
- MTHI/MTLO: HI/LO written on the accepting edge, only when IDLE.
- MFHI/MFLO: o_result is driven combinationally from HI/LO in the accepting cycle; o_result_valid = 1.
- Reset mid-operation: immediately IDLE; HI, LO, counter and operand registers cleared; no partial write.

## Timing
- Reset values: o_stall 0, o_busy 0, o_result 0, o_result_valid 0. HI = LO = 0, state IDLE.
- MDU op accepted on edge E0:
  - RUN occupies edges E1..E_NB_DATA.
  - FIXUP writes HI/LO on edge E_NB_DATA+1.
  - o_busy is high for exactly NB_DATA+1 cycles (NB_DATA = 32 → 33 cycles).
- The first cycle in which MFHI/MFLO can be accepted is the cycle after E_NB_DATA+1. It sees the new values.
- Back-to-back MDU ops: the second op stalls until o_busy falls, then is accepted that same cycle.
- Unrelated instructions never stall; the pipeline overlaps with RUN.
- i_stall high at an IDLE cycle with a valid op: no acceptance, o_stall 0, state unchanged.

## Configuration
- MDU_DIV_EN:
  - Defined: DIV/DIVU are supported as above.
  - Undefined: the divide logic is removed. 0x1A/0x1B are treated as unrecognised: no stall, no state change, HI/LO unchanged.
  - MULT*, MF*, MT* are unaffected in both cases.

## Structure
- mdu_pkg holds:
  - function-code localparams
  - state enum (IDLE/RUN/FIXUP)
  - op-kind encoding (MUL/DIV, signed flag)
- One sub-module, mdu_iter_core: the per-cycle shift/add/subtract step over the {acc, operand} register pair, with counter. It is instantiated once by mdu_sequencer, which keeps the FSM, HI/LO, decode and stall logic.

## Test plan
- MULTU 0xFFFFFFFF × 0x00000002 → after 33 busy cycles HI = 0x00000001, LO = 0xFFFFFFFE.
- MULT −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; o_stall 0 for interleaved ADD instructions.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 10 / 0 → LO = 0xFFFFFFFF, HI = 0x0000000A. Without MDU_DIV_EN: HI/LO keep prior values, o_busy stays 0.
- MULT accepted, then MFLO presented the next cycle → o_stall high 33 cycles, then o_result = LO product with o_result_valid = 1.
- i_rst_n pulsed low during RUN cycle 10 → o_busy 0 and HI = LO = 0 immediately. A subsequent MTHI 0x1234 then MFHI → o_result = 0x00001234.
